// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush/forward control for the 5-stage core with memory-wait watchdog.
// Define HAZARD_FWD_EN for forwarding + load-use stall; otherwise RAW hazards stall until W.
module pipeline_hazard_ctrl #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       Rs1D,
   input  logic [4:0]       Rs2D,
   input  logic [4:0]       Rs1E,
   input  logic [4:0]       Rs2E,
   input  logic [4:0]       RdE,
   input  logic [4:0]       RdM,
   input  logic [4:0]       RdW,
   input  logic             RegWriteE,
   input  logic             RegWriteM,
   input  logic             RegWriteW,
   input  logic             ResultSrcE0,
   input  logic             PCSrcE,
   input  logic             MemReqM,
   input  logic             MemReadyM,
   output logic             StallF,
   output logic             StallD,
   output logic             StallE,
   output logic             StallM,
   output logic             FlushD,
   output logic             FlushE,
   output logic             FlushW,
   output logic [1:0]       ForwardAE,
   output logic [1:0]       ForwardBE,
   output logic             MemErrM,
   output logic [CNT_W-1:0] StallCount
);
   localparam int WW = $clog2(MEM_TIMEOUT + 1);
   typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;
   state_t           r_state, w_next;
   logic [WW-1:0]    r_wait;
   logic             r_err;
   logic [CNT_W-1:0] r_cnt;
   logic             w_miss, w_memwait, w_hz;
   logic [1:0]       w_fa, w_fb;
   assign w_miss    = MemReqM & ~MemReadyM;
   assign w_memwait = w_miss | (r_state == ERROR);
`ifdef HAZARD_FWD_EN
   function automatic logic [1:0] fwd(input logic [4:0] rs);
      return (RegWriteM && RdM != 5'd0 && RdM == rs) ? 2'b10 :
             (RegWriteW && RdW != 5'd0 && RdW == rs) ? 2'b01 : 2'b00;
   endfunction
   assign w_hz = ResultSrcE0 & RegWriteE & (RdE != 5'd0) & ((RdE == Rs1D) | (RdE == Rs2D));
   assign w_fa = fwd(Rs1E);
   assign w_fb = fwd(Rs2E);
`else
   // Without forwarding, any producer still in E or M must reach W before D may advance.
   function automatic logic dep(input logic [4:0] rd, input logic we);
      return we && rd != 5'd0 && (rd == Rs1D || rd == Rs2D);
   endfunction
   logic w_unused;
   assign w_unused = &{1'b0, Rs1E, Rs2E, RdW, RegWriteW, ResultSrcE0};
   assign w_hz = dep(RdE, RegWriteE) | dep(RdM, RegWriteM);
   assign w_fa = 2'b00;
   assign w_fb = 2'b00;
`endif
   always_comb begin
      w_next    = r_state;
      StallF    = 1'b0;
      StallD    = 1'b0;
      StallE    = 1'b0;
      StallM    = 1'b0;
      FlushD    = 1'b0;
      FlushE    = 1'b0;
      FlushW    = 1'b0;
      ForwardAE = rst ? 2'b00 : w_fa;
      ForwardBE = rst ? 2'b00 : w_fb;
      unique case (r_state)
         RUN:      w_next = w_miss ? MEM_WAIT : RUN;
         MEM_WAIT: w_next = MemReadyM ? RUN : (r_wait == WW'(MEM_TIMEOUT - 1)) ? ERROR : MEM_WAIT;
         default:  w_next = ERROR;
      endcase
      if (rst) begin
         FlushD = 1'b1;
         FlushE = 1'b1;
         FlushW = 1'b1;
      end else if (w_memwait) begin
         StallF = 1'b1;
         StallD = 1'b1;
         StallE = 1'b1;
         StallM = 1'b1;
         FlushW = 1'b1;
      end else if (PCSrcE) begin
         FlushD = 1'b1;
         FlushE = 1'b1;
      end else if (w_hz) begin
         StallF = 1'b1;
         StallD = 1'b1;
         FlushE = 1'b1;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= RUN;
         r_wait  <= '0;
         r_err   <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         r_wait  <= (r_state == MEM_WAIT && w_next == MEM_WAIT) ? r_wait + 1'b1 : '0;
         r_err   <= r_err | (w_next == ERROR);
         r_cnt   <= (StallF && !(&r_cnt)) ? r_cnt + 1'b1 : r_cnt;
      end
   end
   assign MemErrM    = r_err;
   assign StallCount = r_cnt;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: randomized + directed bench against a rule-level model of the hazard controller.
module tb_pipeline_hazard_ctrl;
   localparam int TO = 4;
   localparam int CW = 4;
   logic clk = 1'b0;
   logic rst;
   logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
   logic RegWriteE, RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MemReqM, MemReadyM;
   logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErrM;
   logic [1:0] ForwardAE, ForwardBE;
   logic [CW-1:0] StallCount;
   int errors = 0;
   int checks = 0;
   int m_miss = 0;
   int m_cnt = 0;
   bit m_err = 1'b0;
   bit go = 1'b0;
`ifdef HAZARD_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif
   always #5 clk = ~clk;
   pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
      .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteE(RegWriteE), .RegWriteM(RegWriteM),
      .RegWriteW(RegWriteW), .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE), .MemReqM(MemReqM),
      .MemReadyM(MemReadyM), .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
      .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW), .ForwardAE(ForwardAE),
      .ForwardBE(ForwardBE), .MemErrM(MemErrM), .StallCount(StallCount));
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   function automatic logic [1:0] mfwd(input logic [4:0] r);
      if (!FWD) return 2'b00;
      if (RegWriteM && RdM != 0 && RdM == r) return 2'b10;
      if (RegWriteW && RdW != 0 && RdW == r) return 2'b01;
      return 2'b00;
   endfunction
   function automatic bit reads(input logic [4:0] rd, input logic we);
      return we && rd != 0 && (rd == Rs1D || rd == Rs2D);
   endfunction
   // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW,ForwardAE,ForwardBE}
   function automatic logic [10:0] mexp();
      logic [3:0] f;
      bit hz;
      f  = {mfwd(Rs1E), mfwd(Rs2E)};
      hz = FWD ? (ResultSrcE0 && reads(RdE, RegWriteE))
               : (reads(RdE, RegWriteE) || reads(RdM, RegWriteM));
      if (rst) return {7'b0000111, 4'b0};
      if (m_err || (MemReqM && !MemReadyM)) return {7'b1111001, f};
      if (PCSrcE) return {7'b0000110, f};
      if (hz) return {7'b1100010, f};
      return {7'b0000000, f};
   endfunction
   always @(posedge clk) begin : mdl
      logic [10:0] e;
      e = mexp();
      if (rst) begin
         m_miss <= 0;
         m_err  <= 1'b0;
         m_cnt  <= 0;
      end else begin
         if (e[10] && m_cnt < 2**CW - 1) m_cnt <= m_cnt + 1;
         if (!m_err) begin
            if (MemReqM && !MemReadyM) begin
               m_miss <= m_miss + 1;
               if (m_miss + 1 == TO + 1) m_err <= 1'b1;
            end else m_miss <= 0;
         end
      end
   end
   always @(negedge clk) begin
      if (go) begin
         chk("ctrl", {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, ForwardAE, ForwardBE}, mexp());
         chk("memerr", MemErrM, m_err);
         chk("stallcnt", StallCount, m_cnt);
      end
   end
   task automatic idle();
      {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
      {RegWriteE, RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MemReqM, MemReadyM} = '0;
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   initial begin
      idle();
      rst = 1'b1;
      #2 chk("rst_outs", {FlushD, FlushE, FlushW, StallF, ForwardAE}, 6'b111000);
      step();
      go  = 1'b1;
      rst = 1'b0;
      #2 chk("rst_cnt", StallCount, 0);
      chk("rst_err", MemErrM, 0);
      MemReqM = 1'b1;
      #2 chk("miss_stall", {StallF, StallD, StallE, StallM, FlushW, FlushD, FlushE}, 7'b1111100);
      step(); step(); step();
      MemReadyM = 1'b1;
      #2 chk("mem_release", {StallF, StallM, FlushW}, 3'b000);
      step();
      chk("mem_cnt", StallCount, 3);
      idle();
      RegWriteE = 1'b1; ResultSrcE0 = 1'b1; RdE = 5; Rs1D = 5; PCSrcE = 1'b1;
      #2 chk("br_vs_lu", {FlushD, FlushE, StallF, StallD}, 4'b1100);
      step(); idle();
      RegWriteE = 1'b1; ResultSrcE0 = 1'b1; RdE = 5; Rs1D = 5; Rs2D = 1;
      #2 chk("lu_stall", {StallF, StallD, FlushE}, 3'b111);
      step(); idle();
      RegWriteM = 1'b1; RdM = 5; Rs1D = 5; Rs2D = 1;
      #2 chk("lu_once", {StallF, StallD, FlushE}, FWD ? 3'b000 : 3'b111);
      step(); idle();
      RegWriteW = 1'b1; RdW = 5; Rs1E = 5; Rs2E = 1;
      #2 chk("lu_fwd", ForwardAE, FWD ? 2'b01 : 2'b00);
      step(); idle();
      RegWriteE = 1'b1; RdE = 3; Rs2D = 3;
      #2 chk("raw_e", {StallF, StallD, FlushE}, FWD ? 3'b000 : 3'b111);
      step(); idle();
      RegWriteM = 1'b1; RdM = 3; Rs2D = 3;
      #2 chk("raw_m", {StallF, StallD, FlushE}, FWD ? 3'b000 : 3'b111);
      step(); idle();
      RegWriteW = 1'b1; RdW = 3; Rs2D = 3;
      #2 chk("raw_w", {StallF, StallD, FlushE}, 3'b000);
      step(); idle();
      RegWriteM = 1'b1; RegWriteW = 1'b1; RdM = 7; RdW = 7; Rs1E = 7; Rs2E = 9;
      #2 chk("fwd_pri", ForwardAE, FWD ? 2'b10 : 2'b00);
      chk("fwd_none", ForwardBE, 2'b00);
      step(); idle();
      RegWriteM = 1'b1; RegWriteW = 1'b1; RdM = 0; RdW = 9; Rs2E = 0; Rs1E = 9;
      #2 chk("fwd_x0", ForwardBE, 2'b00);
      chk("fwd_w", ForwardAE, FWD ? 2'b01 : 2'b00);
      step(); idle();
      MemReqM = 1'b1;
      step(); step(); step(); step();
      #2 chk("to_pre", MemErrM, 0);
      step();
      chk("to_err", MemErrM, 1);
      MemReqM = 1'b0; MemReadyM = 1'b1; PCSrcE = 1'b1;
      #2 chk("err_hold", {StallF, StallD, StallE, StallM, FlushW, FlushD}, 6'b111110);
      step();
      chk("err_sticky", {MemErrM, StallF}, 2'b11);
      idle();
      MemReqM = 1'b1;
      step(); step();
      rst = 1'b1;
      #2 chk("rst_wait", {FlushD, FlushE, FlushW, StallF, StallM}, 5'b11100);
      step();
      rst = 1'b0; idle();
      #2 chk("post_rst", {MemErrM, StallF, StallCount}, 0);
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(99) < 2);
         Rs1D = 5'($urandom_range(7)); Rs2D = 5'($urandom_range(7));
         Rs1E = 5'($urandom_range(7)); Rs2E = 5'($urandom_range(7));
         RdE = 5'($urandom_range(7)); RdM = 5'($urandom_range(7)); RdW = 5'($urandom_range(7));
         RegWriteE = 1'($urandom_range(1)); RegWriteM = 1'($urandom_range(1));
         RegWriteW = 1'($urandom_range(1)); ResultSrcE0 = 1'($urandom_range(1));
         PCSrcE = ($urandom_range(7) == 0);
         MemReqM = (m_miss > 0 && !m_err) ? 1'b1 : ($urandom_range(3) == 0);
         MemReadyM = ($urandom_range(9) < 6);
         step();
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
